// File: rtl/data_bus_interface_pkg.sv
// Shared types for the data-side bus interface stage.
// Exports bus_state_t, bus_req_t, DEFAULT_BUS_TIMEOUT and word_align().
package data_bus_interface_pkg;

    typedef logic [31:0] uint32;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_ACTIVE,
        BUS_DONE
    } bus_state_t;

    typedef struct packed {
        uint32      addr;
        uint32      wdata;
        logic [3:0] be;
        logic       we;
    } bus_req_t;

    localparam int DEFAULT_BUS_TIMEOUT = 16;

    localparam logic [3:0] BE_WORD = 4'b1111;

    localparam uint32 WORD_MASK = 32'hFFFF_FFFC;

    function automatic uint32 word_align(input uint32 a);
        return a & WORD_MASK;
    endfunction

endpackage

// File: rtl/data_bus_interface_timeout.sv
// Wait-state counter that flags a bus beat running out of time.
// Ports: clk, rst_n, clear_i, enable_i -> expired_o (count reached LIMIT-1).
module bus_timeout_counter #(
    parameter int LIMIT = 16,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == LAST);

    // Saturate at LAST so a caller that keeps enable high
    // does not wrap back into a "fresh" window.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/data_bus_interface.sv
// Data bus interface: runs one word-aligned valid/ready beat per memory
// access, stalls the pipeline meanwhile, returns the raw read word.
// Ports: clk, rst_n; req_* / exception from the memory stage;
// stall, rdata, rdata_valid, bus_error to the pipeline;
// bus_valid/we/addr/wdata/be out and bus_ready/rdata/err in on the bus.
module data_bus_interface
    import data_bus_interface_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_BUS_TIMEOUT,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    input  logic        exception,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        bus_error,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    bus_state_t state_q;
    bus_state_t state_d;
    bus_req_t   req_q;
    bus_req_t   req_d;
    logic       err_q;
    logic       err_d;
    uint32      rdata_q;
    uint32      rdata_d;

    logic in_idle;
    logic in_bus;
    logic in_done;
    logic accept;
    logic tmo_expired;

    assign in_idle = (state_q == BUS_IDLE);
    assign in_bus  = (state_q == BUS_ACTIVE);
    assign in_done = (state_q == BUS_DONE);

    // A store with an empty mask was already suppressed upstream,
    // so it never reaches the bus. Read+write together is a write.
    // Gating with rst_n keeps stall low while reset is held.
    always_comb begin
        accept = 1'b0;
        if (rst_n && !exception) begin
            if (req_write) begin
                accept = (req_mask != 4'b0000);
            end else begin
                accept = req_read;
            end
        end
    end

    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_tmo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (in_idle && accept),
        .enable_i  (in_bus && !bus_ready),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            BUS_IDLE: begin
                if (accept) begin
                    state_d     = BUS_ACTIVE;
                    req_d.addr  = word_align(req_addr);
                    req_d.wdata = req_wdata;
                    req_d.be    = req_write ? req_mask : BE_WORD;
                    req_d.we    = req_write;
                    err_d       = 1'b0;
                end
            end
            BUS_ACTIVE: begin
                // Exceptions are ignored here: a started beat completes.
                if (bus_ready) begin
                    state_d = BUS_DONE;
                    err_d   = bus_err;
                    if (!req_q.we) begin
                        rdata_d = bus_rdata;
                    end
                end else if (tmo_expired) begin
                    state_d = BUS_DONE;
                    err_d   = 1'b1;
                end
            end
            BUS_DONE: begin
                // Pipeline advances this cycle; never re-accept.
                state_d = BUS_IDLE;
            end
            default: begin
                state_d = BUS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BUS_IDLE;
            req_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign stall       = in_bus || (in_idle && accept);
    assign rdata       = rdata_q;
    assign rdata_valid = in_done;
    assign bus_error   = in_done && err_q;
    assign bus_valid   = in_bus;
    assign bus_we      = req_q.we;
    assign bus_addr    = req_q.addr;
    assign bus_wdata   = req_q.wdata;
    assign bus_be      = req_q.be;

endmodule

// File: tb/tb_data_bus_interface.sv
// Bench for data_bus_interface: transaction-level model plus
// per-cycle compare and directed literal expectations.
module tb_data_bus_interface;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_mask = '0;
    logic        exception = 1'b0;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        bus_error;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err = 1'b0;

    always #5 clk = ~clk;

    data_bus_interface #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_read    (req_read),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_mask    (req_mask),
        .exception   (exception),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .bus_error   (bus_error),
        .bus_valid   (bus_valid),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_be      (bus_be),
        .bus_ready   (bus_ready),
        .bus_rdata   (bus_rdata),
        .bus_err     (bus_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act,
                        input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Model: one outstanding transaction, described by its record
    // and how long it has been on the bus.
    bit          m_bus = 0;
    bit          m_done = 0;
    bit          m_err = 0;
    int          m_wait = 0;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_be = '0;
    logic        m_we = 1'b0;

    function automatic bit m_accept();
        if (exception) return 1'b0;
        if (req_write) return (req_mask != 4'b0000);
        return req_read;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_bus = 0;
            m_done = 0;
            m_err = 0;
            m_rdata = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_bus) begin
            if (bus_ready) begin
                m_bus = 0;
                m_done = 1;
                m_err = bus_err;
                if (!m_we) m_rdata = bus_rdata;
            end else if (m_wait == TMO - 1) begin
                m_bus = 0;
                m_done = 1;
                m_err = 1;
            end else begin
                m_wait++;
            end
        end else if (m_accept()) begin
            m_bus = 1;
            m_wait = 0;
            m_we = req_write;
            m_addr = {req_addr[31:2], 2'b00};
            m_wdata = req_wdata;
            m_be = req_write ? req_mask : 4'hF;
        end
    end

    bit          mon_en = 0;
    int          n_stall = 0;
    int          n_valid = 0;
    int          n_rdv = 0;
    logic [31:0] seen_addr = '0;
    logic [31:0] seen_wdata = '0;
    logic [3:0]  seen_be = '0;
    logic        seen_we = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            chkb("stall", stall,
                 m_bus || (rst_n && !m_bus && !m_done && m_accept()));
            chkb("bus_valid", bus_valid, m_bus);
            chkb("rdata_valid", rdata_valid, m_done);
            chkb("bus_error", bus_error, m_done && m_err);
            chk("rdata", rdata, m_rdata);
            if (m_bus) begin
                chkb("bus_we", bus_we, m_we);
                chk("bus_addr", bus_addr, m_addr);
                chk("bus_wdata", bus_wdata, m_wdata);
                chk("bus_be", {28'd0, bus_be}, {28'd0, m_be});
            end
            if (stall) n_stall++;
            if (bus_valid) begin
                if (n_valid == 0) begin
                    seen_addr = bus_addr;
                    seen_wdata = bus_wdata;
                    seen_be = bus_be;
                    seen_we = bus_we;
                end
                n_valid++;
            end
            if (rdata_valid) n_rdv++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        n_stall = 0;
        n_valid = 0;
        n_rdv = 0;
    endtask

    task automatic idle_inputs();
        req_read = 0;
        req_write = 0;
        req_mask = 0;
        exception = 0;
        bus_ready = 0;
        bus_err = 0;
    endtask

    // Issue one request, hold it, and return at the start of the
    // completion cycle. waits<0 means the slave never answers.
    task automatic access(input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] m, input logic [31:0] sd,
                          input logic se, input int waits,
                          input int exc_cycle);
        bit done;
        req_read = rd;
        req_write = wr;
        req_addr = a;
        req_wdata = wd;
        req_mask = m;
        bus_rdata = sd;
        bus_err = se;
        bus_ready = (waits == 0);
        clr_cnt();
        done = 0;
        for (int k = 1; k <= 64 && !done; k++) begin
            tick();
            if (k == exc_cycle) exception = 1;
            if (rdata_valid) done = 1;
            else bus_ready = (waits >= 0) && (k >= waits + 1);
        end
        if (!done) chkb("access_completes", 1'b0, 1'b1);
    endtask

    task automatic finish_acc();
        tick();
        idle_inputs();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        mon_en = 1;
        chk("reset_rdata", rdata, 32'h0);
        chkb("reset_bus_valid", bus_valid, 1'b0);
        chkb("reset_stall", stall, 1'b0);
        chkb("reset_rdata_valid", rdata_valid, 1'b0);
        tick();

        // Load, zero wait.
        access(1, 0, 32'h1006, 32'h0, 4'h0, 32'hA1B2C3D4, 0, 0, -1);
        chk("ld_addr", seen_addr, 32'h1004);
        chk("ld_be", {28'd0, seen_be}, 32'hF);
        chkb("ld_we", seen_we, 1'b0);
        chk("ld_stall_cycles", n_stall, 2);
        chk("ld_rdata", rdata, 32'hA1B2C3D4);
        chkb("ld_rdv", rdata_valid, 1'b1);
        chkb("ld_err", bus_error, 1'b0);
        finish_acc();

        // Store, three wait states.
        access(0, 1, 32'h2002, 32'h55660000, 4'b1100, 32'hFFFFFFFF,
               0, 3, -1);
        chk("st_addr", seen_addr, 32'h2000);
        chk("st_be", {28'd0, seen_be}, 32'hC);
        chk("st_wdata", seen_wdata, 32'h55660000);
        chkb("st_we", seen_we, 1'b1);
        chk("st_valid_cycles", n_valid, 4);
        chk("st_stall_cycles", n_stall, 5);
        chk("st_rdata_kept", rdata, 32'hA1B2C3D4);
        chkb("st_rdv", rdata_valid, 1'b1);
        finish_acc();

        // Timeout.
        access(1, 0, 32'h8000, 32'h0, 4'h0, 32'hDEADBEEF, 0, -1, -1);
        chk("tmo_valid_cycles", n_valid, 16);
        chk("tmo_stall_cycles", n_stall, 17);
        chkb("tmo_err", bus_error, 1'b1);
        chkb("tmo_rdv", rdata_valid, 1'b1);
        chk("tmo_rdata_kept", rdata, 32'hA1B2C3D4);
        finish_acc();
        chkb("tmo_back_idle", bus_valid, 1'b0);

        // Slave error on a store, then a normal read.
        access(0, 1, 32'h300C, 32'h11223344, 4'hF, 32'h0, 1, 0, -1);
        chkb("serr_err", bus_error, 1'b1);
        chk("serr_stall_cycles", n_stall, 2);
        finish_acc();
        access(1, 0, 32'h3010, 32'h0, 4'h0, 32'h12345678, 0, 0, -1);
        chkb("after_err_err", bus_error, 1'b0);
        chk("after_err_rdata", rdata, 32'h12345678);
        chk("after_err_addr", seen_addr, 32'h3010);
        finish_acc();

        // Read and write together act as a write.
        access(1, 1, 32'h4001, 32'h0000BEEF, 4'b0011, 32'h9999, 0, 0, -1);
        chkb("rw_we", seen_we, 1'b1);
        chk("rw_be", {28'd0, seen_be}, 32'h3);
        chk("rw_addr", seen_addr, 32'h4000);
        chk("rw_rdata_kept", rdata, 32'h12345678);
        finish_acc();

        // Exception blocks acceptance in IDLE.
        req_read = 1;
        exception = 1;
        req_addr = 32'h7000;
        clr_cnt();
        tick();
        tick();
        chk("exc_valid_cycles", n_valid, 0);
        chk("exc_stall_cycles", n_stall, 0);
        idle_inputs();

        // Empty-mask store produces no traffic.
        req_write = 1;
        req_mask = 4'b0000;
        req_addr = 32'h7004;
        clr_cnt();
        tick();
        tick();
        chk("m0_valid_cycles", n_valid, 0);
        chk("m0_stall_cycles", n_stall, 0);
        idle_inputs();
        tick();

        // Exception rising mid-beat does not abort it.
        access(1, 0, 32'h5008, 32'h0, 4'h0, 32'hCAFEF00D, 0, 2, 2);
        chk("excbus_rdata", rdata, 32'hCAFEF00D);
        chk("excbus_valid_cycles", n_valid, 3);
        chkb("excbus_rdv", rdata_valid, 1'b1);
        finish_acc();

        // Reset in the middle of a beat.
        req_read = 1;
        req_addr = 32'h6000;
        bus_ready = 0;
        clr_cnt();
        tick();
        tick();
        chkb("rst_mid_valid_before", bus_valid, 1'b1);
        rst_n = 0;
        tick();
        chkb("rst_mid_valid", bus_valid, 1'b0);
        chkb("rst_mid_stall", stall, 1'b0);
        chk("rst_mid_rdata", rdata, 32'h0);
        chkb("rst_mid_rdv", rdata_valid, 1'b0);
        idle_inputs();
        rst_n = 1;
        tick();
        tick();
        chk("rst_mid_no_pulse", n_rdv, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_bus_interface.md
Name: data_bus_interface

Overview:
- Sequential bus-side stage directly downstream of the memory-stage controller.
- Takes the controller's read/write strobes, byte mask, address and store data, and runs one word-aligned transaction on the data bus using a valid/ready handshake.
- Stalls the pipeline while the transaction is in flight and returns the raw 32-bit word, which feeds the controller's dataMemOut for load extraction.
- Flags bus errors and timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: cycles bus_valid may wait for bus_ready before the access is aborted with bus_error.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the wait counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_read  in  1  load strobe from the memory-stage controller.
- req_write  in  1  store strobe from the memory-stage controller (already gated by exception).
- req_addr  in  32  byte address (uint32).
- req_wdata  in  32  store data, already lane-aligned.
- req_mask  in  4  byte enables for stores.
- exception  in  1  pipeline exception; blocks acceptance of a new request.
- stall  out  1  holds the pipeline; the request inputs must stay stable while stall=1.
- rdata  out  32  registered raw word read from the bus.
- rdata_valid  out  1  one-cycle pulse when the access completes.
- bus_error  out  1  one-cycle pulse when the access completes with bus_err or timeout.
- bus_valid  out  1  bus request valid.
- bus_we  out  1  1=write, 0=read.
- bus_addr  out  32  word-aligned address: {req_addr[31:2], 2'b00}.
- bus_wdata  out  32  write data.
- bus_be  out  4  byte enables: 4'b1111 for reads, req_mask for writes.
- bus_ready  in  1  slave accepts/completes the current beat.
- bus_rdata  in  32  read data; valid when bus_ready=1.
- bus_err  in  1  slave error; sampled with bus_ready.

Behaviour:

Reset:
- rst_n=0 at a clk edge puts the FSM in IDLE and clears rdata, counter and all latched request fields to 0.
- Outputs while in reset: bus_valid=0, rdata_valid=0, bus_error=0, stall=0.
- Reset mid-transaction drops bus_valid on the next cycle with no completion pulse.

FSM states: IDLE, BUS, DONE.

IDLE:
- accept = (req_read|req_write) & ~exception.
- On accept: latch addr/wdata/mask/we, clear the counter, go to BUS. stall=1 combinationally in the accept cycle.
- Store with req_mask==0 (misaligned store, already suppressed upstream): no bus traffic, stall=0, stays in IDLE.
- req_read and req_write both 1: treated as a write.

BUS:
- bus_valid=1; bus_we/bus_addr/bus_wdata/bus_be driven from the latched registers and held stable until bus_ready. stall=1.
- bus_ready=1: capture bus_rdata into rdata (reads only; writes leave rdata unchanged), record err=bus_err, go to DONE.
- Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without ready: err=1, go to DONE. bus_valid deasserts the next cycle.
- exception asserting during BUS does not abort the transaction; a started beat always completes.

DONE:
- stall=0, rdata_valid=1, bus_error=err. Next state is IDLE unconditionally; the pipeline advances this cycle, so the same request is never re-accepted.

Timing:
- Zero-wait-slave latency: request seen in cycle 0, bus_valid in cycle 1, DONE in cycle 2. stall is high for exactly 2 cycles; each wait state adds 1.
- Back-to-back accesses: the minimum spacing is 3 cycles per access.

Decomposition:
- Add to Common: typedef enum logic [1:0] {BUS_IDLE, BUS_ACTIVE, BUS_DONE} bus_state_t; typedef struct packed {uint32 addr; uint32 wdata; logic [3:0] be; logic we;} bus_req_t; localparam DEFAULT_BUS_TIMEOUT = 16.
- One sub-module: bus_timeout_counter (clear, enable, expired output) for reuse by the instruction-fetch bus interface.

Test Plan:
- Load, zero wait: req_read=1, req_addr=0x1006, bus_ready=1 in cycle 1, bus_rdata=0xA1B2C3D4 -> bus_addr=0x1004, bus_be=4'b1111, stall high in cycles 0-1, rdata=0xA1B2C3D4 with rdata_valid in cycle 2, bus_error=0.
- Store with 3 wait states: req_write=1, addr=0x2002, mask=4'b1100, wdata=0x55660000 -> bus_valid held with stable bus_addr=0x2000/bus_be=4'b1100/bus_wdata for 4 cycles, stall high 5 cycles, rdata unchanged.
- Timeout: read with bus_ready held 0 -> bus_valid high exactly 16 cycles, bus_error=1 and rdata_valid=1 in DONE, then IDLE.
- Slave error: bus_ready=1 with bus_err=1 on a store -> bus_error pulse in cycle 2; a following read starts normally.
- Exception blocking: req_read=1 with exception=1 in IDLE -> no bus_valid, stall=0. exception rising during BUS -> the transaction still completes.
- Reset mid-access: rst_n=0 while in BUS -> the next cycle bus_valid=0, stall=0, rdata=0, and no rdata_valid pulse.
